// File: rtl/ub_banked_read_sched.sv
// ub_banked_read_sched
// Holds a 2x2 parity-banked 2-D tile (EXT_X by EXT_Y words) and replays it in
// row-major order as a valid/ready stream. An internal x/y loop counter drives
// the reads, so the consumer needs no schedule of its own.
//
// Optional feature: define UB_READ_BOUNDS_CHECK_EN to drop out-of-range writes
// and raise the sticky err flag. When it is undefined, out-of-range addresses
// wrap into the bank silently and err is tied low.
module ub_banked_read_sched #(
    parameter int DATA_W      = 16,
    parameter int EXT_X       = 64,
    parameter int EXT_Y       = 64,
    parameter int START_DELAY = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              start,
    input  logic              wen,
    input  logic [15:0]       waddr_x,
    input  logic [15:0]       waddr_y,
    input  logic [DATA_W-1:0] wdata,
    input  logic              rd_ready,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [15:0]       rd_x,
    output logic [15:0]       rd_y,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int HALF_X = EXT_X / 2;
    localparam int BANK_D = (EXT_X / 2) * (EXT_Y / 2);
    localparam int BA_W   = (BANK_D > 1) ? $clog2(BANK_D) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        RUN   = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t            state_reg, state_next;
    logic [15:0]       x_reg, x_next;
    logic [15:0]       y_reg, y_next;
    logic [15:0]       delay_reg, delay_next;
    logic              rd_valid_reg;
    logic [15:0]       rd_x_reg, rd_y_reg;
    logic [1:0]        rd_sel_reg;
    logic              issue;
    logic              done_c;

    // ---------------- write-side address decode ----------------
    logic [1:0]        wbank;
    logic [BA_W-1:0]   wbank_addr;
    logic              wok;

    assign wbank      = {waddr_y[0], waddr_x[0]};
    assign wbank_addr = BA_W'({16'b0, waddr_x >> 1} + {16'b0, waddr_y >> 1} * 32'(HALF_X));

`ifdef UB_READ_BOUNDS_CHECK_EN
    logic err_reg;

    assign wok = ({16'b0, waddr_x} < 32'(EXT_X)) && ({16'b0, waddr_y} < 32'(EXT_Y));

    // Sticky flag for any write that falls outside the tile; cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            err_reg <= 1'b0;
        else if (wen && !wok)
            err_reg <= 1'b1;
    end

    assign err = err_reg;
`else
    assign wok = 1'b1;
    assign err = 1'b0;
`endif

    // ---------------- read-side address decode ----------------
    logic [1:0]        rbank;
    logic [BA_W-1:0]   rbank_addr;

    assign rbank      = {y_reg[0], x_reg[0]};
    assign rbank_addr = BA_W'({16'b0, x_reg >> 1} + {16'b0, y_reg >> 1} * 32'(HALF_X));

    // ---------------- storage banks ----------------
    logic [DATA_W-1:0] bank_dout [4];

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_bank
            logic [DATA_W-1:0] mem [BANK_D];
            logic [DATA_W-1:0] q;

            // Bank write port; active in every FSM state.
            always_ff @(posedge clk) begin
                if (wen && wok && (wbank == 2'(gi)))
                    mem[wbank_addr] <= wdata;
            end

            // Registered read, only updated on issue so the word holds while stalled.
            // A write to the same address in the same cycle is not yet visible here.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n)
                    q <= '0;
                else if (issue && (rbank == 2'(gi)))
                    q <= mem[rbank_addr];
            end

            assign bank_dout[gi] = q;
        end
    endgenerate

    // ---------------- FSM ----------------
    // State and loop-counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            x_reg     <= '0;
            y_reg     <= '0;
            delay_reg <= '0;
        end else begin
            state_reg <= state_next;
            x_reg     <= x_next;
            y_reg     <= y_next;
            delay_reg <= delay_next;
        end
    end

    // Next-state, loop-counter advance, read issue and done generation.
    always_comb begin
        state_next = state_reg;
        x_next     = x_reg;
        y_next     = y_reg;
        delay_next = delay_reg;
        issue      = 1'b0;
        done_c     = 1'b0;

        if (flush) begin
            state_next = IDLE;
            x_next     = '0;
            y_next     = '0;
            delay_next = '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    x_next     = '0;
                    y_next     = '0;
                    delay_next = '0;
                    if (start)
                        state_next = (START_DELAY > 0) ? DELAY : RUN;
                end
                DELAY: begin
                    if (delay_reg == 16'(START_DELAY - 1)) begin
                        delay_next = '0;
                        state_next = RUN;
                    end else begin
                        delay_next = delay_reg + 16'd1;
                    end
                end
                RUN: begin
                    if (!rd_valid_reg || rd_ready) begin
                        issue = 1'b1;
                        if (x_reg == 16'(EXT_X - 1)) begin
                            x_next = '0;
                            if (y_reg == 16'(EXT_Y - 1)) begin
                                y_next     = '0;
                                state_next = DRAIN;
                            end else begin
                                y_next = y_reg + 16'd1;
                            end
                        end else begin
                            x_next = x_reg + 16'd1;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_valid_reg && rd_ready) begin
                        done_c     = 1'b1;
                        state_next = IDLE;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    // ---------------- output register ----------------
    // Valid flag and coordinates of the word held in the bank output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_valid_reg <= 1'b0;
            rd_x_reg     <= '0;
            rd_y_reg     <= '0;
            rd_sel_reg   <= '0;
        end else begin
            if (flush)
                rd_valid_reg <= 1'b0;
            else if (issue)
                rd_valid_reg <= 1'b1;
            else if (rd_ready)
                rd_valid_reg <= 1'b0;

            if (issue) begin
                rd_x_reg   <= x_reg;
                rd_y_reg   <= y_reg;
                rd_sel_reg <= rbank;
            end
        end
    end

    assign rd_valid = rd_valid_reg;
    assign rd_data  = bank_dout[rd_sel_reg];
    assign rd_x     = rd_x_reg;
    assign rd_y     = rd_y_reg;
    assign busy     = (state_reg != IDLE);
    assign done     = done_c;

endmodule

// File: tb/tb_ub_banked_read_sched.sv
// Testbench for ub_banked_read_sched on a 4x4 tile. Stimulus pushes the
// expected beats into a queue; a negedge monitor pops and compares on every
// accepted beat and checks the held word on stalled cycles. A second instance
// with START_DELAY=3 checks the start-to-first-valid latency.
module tb_ub_banked_read_sched;

    localparam int DW = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          flush = 1'b0;
    logic          start = 1'b0;
    logic          wen = 1'b0;
    logic [15:0]   waddr_x = '0;
    logic [15:0]   waddr_y = '0;
    logic [DW-1:0] wdata = '0;
    logic          rd_ready = 1'b1;
    logic          rd_valid;
    logic [DW-1:0] rd_data;
    logic [15:0]   rd_x, rd_y;
    logic          busy, done, err;

    logic          flush_d = 1'b0;
    logic          start_d = 1'b0;
    logic          rd_valid_d;
    logic [DW-1:0] rd_data_d;
    logic [15:0]   rd_x_d, rd_y_d;
    logic          busy_d, done_d, err_d;

    always #5 clk = ~clk;

    ub_banked_read_sched #(.DATA_W(DW), .EXT_X(4), .EXT_Y(4), .START_DELAY(0)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .start(start), .wen(wen),
        .waddr_x(waddr_x), .waddr_y(waddr_y), .wdata(wdata), .rd_ready(rd_ready),
        .rd_valid(rd_valid), .rd_data(rd_data), .rd_x(rd_x), .rd_y(rd_y),
        .busy(busy), .done(done), .err(err)
    );

    ub_banked_read_sched #(.DATA_W(DW), .EXT_X(4), .EXT_Y(4), .START_DELAY(3)) dut_d (
        .clk(clk), .rst_n(rst_n), .flush(flush_d), .start(start_d), .wen(wen),
        .waddr_x(waddr_x), .waddr_y(waddr_y), .wdata(wdata), .rd_ready(rd_ready),
        .rd_valid(rd_valid_d), .rd_data(rd_data_d), .rd_x(rd_x_d), .rd_y(rd_y_d),
        .busy(busy_d), .done(done_d), .err(err_d)
    );

    typedef struct {
        logic [DW-1:0] d;
        int            x;
        int            y;
        bit            last;
    } exp_t;

    exp_t          exp_q[$];
    logic [DW-1:0] model [4][4];   // [y][x]
    int            checks = 0;
    int            passes = 0;
    int            accepted = 0;
    bit            tile_done = 1'b0;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got === want)
            passes++;
        else
            $display("FAIL %s: got %h, want %h", name, got, want);
    endtask

    // Scoreboard monitor: compare each accepted beat, and the held word while stalled.
    always @(negedge clk) begin
        if (rst_n && rd_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                $display("FAIL beat_unexpected: got data=%h x=%0d y=%0d, want no beat",
                         rd_data, rd_x, rd_y);
            end else if (rd_ready) begin
                exp_t e;
                e = exp_q.pop_front();
                checks++;
                if (rd_data === e.d && rd_x === 16'(e.x) && rd_y === 16'(e.y) && done === e.last)
                    passes++;
                else
                    $display("FAIL beat: got data=%h x=%0d y=%0d done=%b, want data=%h x=%0d y=%0d done=%b",
                             rd_data, rd_x, rd_y, done, e.d, e.x, e.y, e.last);
                accepted++;
                if (e.last) tile_done = 1'b1;
            end else begin
                checks++;
                if (rd_data === exp_q[0].d && rd_x === 16'(exp_q[0].x) && rd_y === 16'(exp_q[0].y)
                    && done === 1'b0)
                    passes++;
                else
                    $display("FAIL stall_hold: got data=%h x=%0d y=%0d done=%b, want data=%h x=%0d y=%0d done=0",
                             rd_data, rd_x, rd_y, done, exp_q[0].d, exp_q[0].x, exp_q[0].y);
            end
        end
    end

    task automatic push_tile();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++)
                exp_q.push_back('{model[y][x], x, y, (x == 3 && y == 3)});
        tile_done = 1'b0;
        accepted  = 0;
    endtask

    task automatic write_word(input int x, input int y, input logic [DW-1:0] d);
        wen = 1'b1; waddr_x = 16'(x); waddr_y = 16'(y); wdata = d;
        @(posedge clk); #1;
        wen = 1'b0;
    endtask

    task automatic fill();
        for (int y = 0; y < 4; y++)
            for (int x = 0; x < 4; x++) begin
                model[y][x] = DW'(16 * y + x);
                write_word(x, y, model[y][x]);
            end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (!tile_done && n < 300) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk(name, {31'b0, tile_done}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        chk("reset_rd_valid", {31'b0, rd_valid}, 32'd0);
        chk("reset_rd_data", {16'b0, rd_data}, 32'd0);
        chk("reset_rd_xy", {rd_y, rd_x}, 32'd0);
        chk("reset_busy_done_err", {29'b0, busy, done, err}, 32'd0);
        @(posedge clk); #1;

        // Full-throughput replay
        fill();
        push_tile();
        pulse_start();
        @(negedge clk);
        chk("t1_busy_after_start", {31'b0, busy}, 32'd1);
        chk("t1_no_valid_yet", {31'b0, rd_valid}, 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t1_first_valid", {31'b0, rd_valid}, 32'd1);
        wait_done("t1_done_seen");
        @(negedge clk);
        chk("t1_busy_low_after_done", {30'b0, busy, done}, 32'd0);
        @(posedge clk); #1;

        // Stalled replay with rd_ready alternating
        push_tile();
        rd_ready = 1'b1;
        pulse_start();
        begin
            int n = 0;
            while (!tile_done && n < 300) begin
                @(posedge clk); #1;
                rd_ready = ~rd_ready;
                n++;
            end
        end
        chk("t2_done_seen", {31'b0, tile_done}, 32'd1);
        chk("t2_beats", 32'(accepted), 32'd16);
        rd_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        // START_DELAY=3 instance: rd_valid rises 5 cycles after the start cycle
        start_d = 1'b1;
        @(posedge clk); #1;
        start_d = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            chk($sformatf("t3_valid_cycle_%0d", i), {31'b0, rd_valid_d}, (i == 5) ? 32'd1 : 32'd0);
        end
        chk("t3_first_word", {rd_x_d, rd_data_d}, 32'd0);
        chk("t3_busy", {31'b0, busy_d}, 32'd1);
        repeat (25) @(posedge clk);
        #1;
        chk("t3_idle_after", {31'b0, busy_d}, 32'd0);

        // Flush on beat 5
        push_tile();
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t4_flush_valid", {31'b0, rd_valid}, 32'd0);
        chk("t4_flush_busy_done", {30'b0, busy, done}, 32'd0);
        chk("t4_beats_before_flush", 32'(accepted), 32'd5);
        @(posedge clk); #1;
        @(negedge clk);
        chk("t4_still_idle", {30'b0, busy, rd_valid}, 32'd0);
        @(posedge clk); #1;

        // Replay after flush starts at (0,0)
        push_tile();
        pulse_start();
        wait_done("t5_done_seen");
        @(posedge clk); #1;

        // Write (1,1) in the cycle its read issues: old value comes out
        push_tile();
        pulse_start();
        repeat (5) @(posedge clk);
        #1;
        write_word(1, 1, 16'hBEEF);
        wait_done("t6_done_seen");
        model[1][1] = 16'hBEEF;
        @(posedge clk); #1;
        push_tile();
        pulse_start();
        wait_done("t6_replay_done");
        @(posedge clk); #1;

        // Out-of-range write
        write_word(4, 0, 16'hDEAD);
        @(negedge clk);
`ifdef UB_READ_BOUNDS_CHECK_EN
        chk("t7_err", {31'b0, err}, 32'd1);
        @(posedge clk); #1;
        push_tile();
        pulse_start();
        wait_done("t7_unchanged_replay");
`else
        chk("t7_err", {31'b0, err}, 32'd0);
`endif
        @(posedge clk); #1;
        chk("final_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
